// File: rtl/anc_lms_sequencer_if.sv
// Sample-in / FIR-control / DAC-out bundle of the ANC LMS sequencer.
// master drives the upstream sample and FIR feedback; slave is the sequencer.
interface anc_lms_sequencer_if;
  logic [15:0] ref_in;
  logic [15:0] err_in;
  logic        in_valid;
  logic        in_ready;
  logic        fir_go;
  logic [31:0] fir_ff_in;
  logic [31:0] fir_weight_adjust;
  logic        fir_done;
  logic [31:0] fir_out;
  logic        fir_out_valid;
  logic [15:0] dac_out;
  logic        dac_valid;
  logic        timeout_err;

  modport master (
    output ref_in, err_in, in_valid, fir_done, fir_out, fir_out_valid,
    input  in_ready, fir_go, fir_ff_in, fir_weight_adjust, dac_out, dac_valid, timeout_err
  );

  modport slave (
    input  ref_in, err_in, in_valid, fir_done, fir_out, fir_out_valid,
    output in_ready, fir_go, fir_ff_in, fir_weight_adjust, dac_out, dac_valid, timeout_err
  );
endinterface

// File: rtl/anc_lms_sequencer.sv
// Per-sample LMS control stage: latch ref/err, launch the FIR, wait with a
// watchdog, then emit the negated and saturated FIR output to the DAC path.
module anc_lms_sequencer #(
  parameter int unsigned        FRAC    = 15,
  parameter logic signed [15:0] MU      = 16'sd328,
  parameter int unsigned        TIMEOUT = 512
) (
  input logic                 clk,
  input logic                 rst,
  anc_lms_sequencer_if.slave  seq_if
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StOutput} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       ff_q, ff_d;
  logic [31:0]       wadj_q, wadj_d;
  logic [31:0]       cap_q, cap_d;
  logic [15:0]       dac_q, dac_d;
  logic              timeout_q, timeout_d;
  logic              in_ready_q, fir_go_q, dac_valid_q;

  logic signed [31:0] mu_ext, err_ext, prod;
  logic        [31:0] fir_sel;
  logic signed [32:0] neg;
  logic        [15:0] sat_val;

  always_comb begin
    mu_ext  = 32'(MU);
    err_ext = 32'($signed(seq_if.err_in));
    prod    = mu_ext * err_ext;

    // A done without its qualifier falls back on the value captured earlier in WAIT.
    fir_sel = seq_if.fir_out_valid ? seq_if.fir_out : cap_q;
    neg     = -(33'($signed(fir_sel)));
    if (neg > 33'sd32767) begin
      sat_val = 16'h7fff;
    end else if (neg < -33'sd32768) begin
      sat_val = 16'h8000;
    end else begin
      sat_val = neg[15:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ff_d      = ff_q;
    wadj_d    = wadj_q;
    cap_d     = cap_q;
    dac_d     = dac_q;
    timeout_d = timeout_q;
    unique case (state_q)
      StIdle: begin
        if (seq_if.in_valid) begin
          ff_d    = {{16{seq_if.ref_in[15]}}, seq_if.ref_in};
          wadj_d  = prod >>> FRAC;
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (seq_if.fir_out_valid) begin
          cap_d = seq_if.fir_out;
        end
        if (seq_if.fir_done) begin
          dac_d   = sat_val;
          state_d = StOutput;
        end else if (cnt_q == CntLast) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end
      end
      StOutput: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ff_q        <= '0;
      wadj_q      <= '0;
      cap_q       <= '0;
      dac_q       <= '0;
      timeout_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      fir_go_q    <= 1'b0;
      dac_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ff_q        <= ff_d;
      wadj_q      <= wadj_d;
      cap_q       <= cap_d;
      dac_q       <= dac_d;
      timeout_q   <= timeout_d;
      in_ready_q  <= (state_d == StIdle);
      fir_go_q    <= (state_d == StLaunch);
      dac_valid_q <= (state_d == StOutput);
    end
  end

  assign seq_if.in_ready          = in_ready_q;
  assign seq_if.fir_go            = fir_go_q;
  assign seq_if.fir_ff_in         = ff_q;
  assign seq_if.fir_weight_adjust = wadj_q;
  assign seq_if.dac_out           = dac_q;
  assign seq_if.dac_valid         = dac_valid_q;
  assign seq_if.timeout_err       = timeout_q;

endmodule

// File: tb/tb_anc_lms_sequencer.sv
// Randomized bench for anc_lms_sequencer with a behavioural FIR responder
// and an arithmetic reference model for the update term and DAC value.
module tb_anc_lms_sequencer;

  localparam int unsigned TO = 512;

  logic clk = 1'b0;
  logic rst = 1'b1;

  anc_lms_sequencer_if sif();

  anc_lms_sequencer #(
    .FRAC    (15),
    .MU      (16'sd328),
    .TIMEOUT (TO)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .seq_if (sif)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_dac;
  logic        exp_to;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // floor(MU * err / 2^15) as a 32-bit pattern
  function automatic logic [31:0] model_wadj(input logic [15:0] e);
    longint p;
    longint q;
    p = 64'sd328 * longint'($signed(e));
    q = p / 32768;
    if ((p < 0) && (q * 32768 != p)) q = q - 1;
    return q[31:0];
  endfunction

  function automatic logic [15:0] model_dac(input logic [31:0] fo);
    longint n;
    n = -longint'($signed(fo));
    if (n > 32767) n = 32767;
    if (n < -32768) n = -32768;
    return n[15:0];
  endfunction

  // Called at a negedge where the DUT should be idle. mode: 0 normal, 1 hang, 2 early valid.
  task automatic run_frame(input logic [15:0] rf, input logic [15:0] er, input int lat,
                           input logic [31:0] fo, input int mode, input logic keep,
                           input logic [31:0] pre);
    logic [31:0] exp_ff;
    logic [31:0] exp_w;
    int n;
    logic seen_dv;
    logic extra_go;
    exp_ff   = {{16{rf[15]}}, rf};
    exp_w    = model_wadj(er);
    seen_dv  = 1'b0;
    extra_go = 1'b0;
    sif.ref_in   = rf;
    sif.err_in   = er;
    sif.in_valid = 1'b1;
    check_eq("accept_ready", 32'(sif.in_ready), 1);
    @(negedge clk);
    if (!keep) sif.in_valid = 1'b0;
    check_eq("go_pulse", 32'(sif.fir_go), 1);
    check_eq("launch_busy", 32'(sif.in_ready), 0);
    check_eq("ff_in", sif.fir_ff_in, exp_ff);
    check_eq("wadj", sif.fir_weight_adjust, exp_w);
    if (mode == 1) begin
      n = 0;
      while (n < int'(TO) + 10) begin
        @(negedge clk);
        n++;
        if (sif.dac_valid) seen_dv = 1'b1;
        if (sif.fir_go) extra_go = 1'b1;
        if (sif.in_ready) break;
      end
      exp_to = 1'b1;
      check_eq("wd_cycles", n, TO + 1);
      check_eq("wd_no_dac", 32'(seen_dv), 0);
      check_eq("wd_no_go", 32'(extra_go), 0);
      check_eq("wd_err", 32'(sif.timeout_err), 1);
      check_eq("wd_dac_hold", 32'(sif.dac_out), 32'(exp_dac));
    end else begin
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        if (sif.fir_go) extra_go = 1'b1;
        if (mode == 2 && i == lat / 2) begin
          sif.fir_out_valid = 1'b1;
          sif.fir_out       = pre;
        end else begin
          sif.fir_out_valid = 1'b0;
          sif.fir_out       = $urandom;
        end
      end
      check_eq("hold_ff", sif.fir_ff_in, exp_ff);
      check_eq("hold_wadj", sif.fir_weight_adjust, exp_w);
      check_eq("single_go", 32'(extra_go), 0);
      check_eq("wait_busy", 32'(sif.in_ready), 0);
      sif.fir_done = 1'b1;
      if (mode == 2) begin
        sif.fir_out_valid = 1'b0;
        sif.fir_out       = ~pre;
        exp_dac           = model_dac(pre);
      end else begin
        sif.fir_out_valid = 1'b1;
        sif.fir_out       = fo;
        exp_dac           = model_dac(fo);
      end
      @(negedge clk);
      sif.fir_done      = 1'b0;
      sif.fir_out_valid = 1'b0;
      check_eq("dac_valid", 32'(sif.dac_valid), 1);
      check_eq("dac_out", 32'(sif.dac_out), 32'(exp_dac));
      check_eq("out_busy", 32'(sif.in_ready), 0);
      @(negedge clk);
      check_eq("dac_pulse", 32'(sif.dac_valid), 0);
      check_eq("ready_back", 32'(sif.in_ready), 1);
      check_eq("to_flag", 32'(sif.timeout_err), 32'(exp_to));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_ready"}, 32'(sif.in_ready), 1);
    check_eq({tag, "_go"}, 32'(sif.fir_go), 0);
    check_eq({tag, "_dv"}, 32'(sif.dac_valid), 0);
    check_eq({tag, "_to"}, 32'(sif.timeout_err), 0);
    check_eq({tag, "_ff"}, sif.fir_ff_in, 0);
    check_eq({tag, "_wadj"}, sif.fir_weight_adjust, 0);
    check_eq({tag, "_dac"}, 32'(sif.dac_out), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout got=hang expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic extra_go;
    int   mode;
    int   lat;
    logic [31:0] fo;
    sif.ref_in        = '0;
    sif.err_in        = '0;
    sif.in_valid      = 1'b0;
    sif.fir_done      = 1'b0;
    sif.fir_out       = '0;
    sif.fir_out_valid = 1'b0;
    exp_dac = '0;
    exp_to  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("por");
    rst = 1'b0;
    @(negedge clk);

    // Directed frames
    run_frame(-16'sd1000, 16'sd16384, 131, 32'd1000, 0, 1'b0, 0);
    run_frame(16'd1234, 16'hffff, 5, 32'h0001_2345, 0, 1'b0, 0);
    run_frame(16'h8000, 16'h7fff, 3, 32'h8000_0000, 0, 1'b0, 0);
    run_frame(16'h7fff, 16'h8000, 7, 32'hffff_0000, 0, 1'b0, 0);
    run_frame(16'h0042, 16'h0100, 9, 32'h0, 2, 1'b0, 32'h0000_0100);

    // Spurious done while idle
    sif.fir_done      = 1'b1;
    sif.fir_out_valid = 1'b1;
    sif.fir_out       = 32'd5;
    @(negedge clk);
    sif.fir_done      = 1'b0;
    sif.fir_out_valid = 1'b0;
    check_eq("spur_ready", 32'(sif.in_ready), 1);
    check_eq("spur_go", 32'(sif.fir_go), 0);
    check_eq("spur_dv", 32'(sif.dac_valid), 0);
    check_eq("spur_dac", 32'(sif.dac_out), 32'(exp_dac));

    // in_valid held continuously: back-to-back accepts
    for (int i = 0; i < 4; i++) begin
      run_frame(16'($urandom), 16'($urandom), int'($urandom_range(1, 12)), $urandom, 0,
                (i != 3), 0);
    end

    // Watchdog, then a normal frame with the flag still set
    run_frame(16'h1111, 16'h2222, 0, 0, 1, 1'b0, 0);
    run_frame(16'hfff0, 16'h0400, 20, 32'hffff_fc00, 0, 1'b0, 0);

    // Randomized frames
    for (int i = 0; i < 20; i++) begin
      mode = ($urandom_range(0, 3) == 0) ? 2 : 0;
      lat  = int'($urandom_range(3, 40));
      fo   = ($urandom_range(0, 1) == 0) ? 32'($signed(17'($urandom))) : $urandom;
      run_frame(16'($urandom), 16'($urandom), lat, fo, mode, 1'b0, $urandom);
    end

    // Reset mid-WAIT
    sif.ref_in   = 16'h5555;
    sif.err_in   = 16'h3333;
    sif.in_valid = 1'b1;
    @(negedge clk);
    sif.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    rst = 1'b0;
    exp_dac  = '0;
    exp_to   = 1'b0;
    extra_go = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sif.fir_done      = i[0];
      sif.fir_out_valid = i[0];
      sif.fir_out       = $urandom;
      @(negedge clk);
      if (sif.fir_go || sif.dac_valid) extra_go = 1'b1;
    end
    sif.fir_done      = 1'b0;
    sif.fir_out_valid = 1'b0;
    check_eq("postrst_quiet", 32'(extra_go), 0);
    check_eq("postrst_ready", 32'(sif.in_ready), 1);
    run_frame(16'h0010, 16'hc000, 10, 32'h0000_7fff, 0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
